regfile_dump_reader: RTL and testbench

//  Debug-side reader for the CPU register file. On a start pulse it walks all

---
 rtl/regdump_pkg.sv | 20 ++
 rtl/word_serializer.sv | 39 +++
 rtl/regfile_dump_reader.sv | 126 ++++++++++++
 tb/tb_regfile_dump_reader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regdump_pkg.sv
// Shared definitions for the register-file dump reader: FSM state encoding and word/byte sizing.
package regdump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SEND  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_CKSUM = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int BYTES_PER_WORD     = DATA_WIDTH_DEFAULT / 8;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Holds one register word and presents it a byte at a time, least significant byte first.
module word_serializer
    import regdump_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [7:0]            tx_byte,
    output logic                  last
);

    localparam int BPW   = bytes_per_word(DATA_WIDTH);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_WIDTH-1:0] word;
    logic [CNT_W-1:0]      byte_cnt;

    assign last    = (byte_cnt == CNT_W'(BPW - 1));
    assign tx_byte = word[7:0];

    // A shift on the final byte leaves the word alone; the next load refills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (load) begin
            word     <= data;
            byte_cnt <= '0;
        end else if (shift && !last) begin
            word     <= word >> 8;
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks the register file through one read port and streams every word as LE bytes.
// Optional trailing XOR checksum byte when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NREGS      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NREGS - 1);

    // Byte stream: o_tx_valid/o_tx_data come only from registered state and
    // hold until i_tx_ready is seen in the same cycle; ready never feeds valid.
    state_e     state;
    state_e     next_state;
    logic       load;
    logic       shift;
    logic [7:0] ser_byte;
    logic       ser_last;

    word_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .clk     (clk),
        .rst_n   (i_rst_n),
        .load    (load),
        .shift   (shift),
        .data    (i_rd_data),
        .tx_byte (ser_byte),
        .last    (ser_last)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            ST_IDLE: if (i_start) next_state = ST_LOAD;
            ST_LOAD: begin
                load       = 1'b1;
                next_state = ST_SEND;
            end
            ST_SEND: if (i_tx_ready) begin
                shift = 1'b1;
                if (ser_last) next_state = ST_NEXT;
            end
            ST_NEXT: begin
                if (o_rd_addr == LAST_ADDR) begin
`ifdef REGDUMP_CHECKSUM_EN
                    next_state = ST_CKSUM;
`else
                    next_state = ST_DONE;
`endif
                end else begin
                    next_state = ST_LOAD;
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            ST_CKSUM: if (i_tx_ready) next_state = ST_DONE;
`endif
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // The address only moves in NEXT, so it is settled throughout LOAD.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_addr <= '0;
        end else if (state == ST_IDLE && i_start) begin
            o_rd_addr <= '0;
        end else if (state == ST_NEXT && o_rd_addr != LAST_ADDR) begin
            o_rd_addr <= o_rd_addr + ADDR_WIDTH'(1);
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    logic [7:0] cksum;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cksum <= '0;
        end else if (state == ST_IDLE && i_start) begin
            cksum <= '0;
        end else if (state == ST_SEND && i_tx_ready) begin
            cksum <= cksum ^ ser_byte;
        end
    end

    assign o_tx_valid = (state == ST_SEND) || (state == ST_CKSUM);

    always_comb begin
        o_tx_data = 8'h00;
        if (state == ST_SEND)       o_tx_data = ser_byte;
        else if (state == ST_CKSUM) o_tx_data = cksum;
    end
`else
    assign o_tx_valid = (state == ST_SEND);

    always_comb begin
        o_tx_data = 8'h00;
        if (state == ST_SEND) o_tx_data = ser_byte;
    end
`endif

    assign o_busy = (state != ST_IDLE) && (state != ST_DONE);
    assign o_done = (state == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: table of dump scenarios plus reset,
// held-start and small-configuration sequences, checked against a byte-stream model.
module tb_regfile_dump_reader;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int BPW = DW / 8;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int EXP_DONE   = 1 + 6 * NR + CK;
    localparam int SMALL_DONE = 1 + 4 * 4 + CK;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          ready;
    logic          busy, done, valid;
    logic [7:0]    data;
    logic [AW-1:0] addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] regs [NR];

    logic          s_start;
    logic          s_busy, s_done, s_valid;
    logic [7:0]    s_data;
    logic [1:0]    s_addr;
    logic [15:0]   s_rd_data;
    logic [15:0]   regs_s [4];

    int n_cmp = 0;
    int n_err = 0;
    int cycle_cnt = 0;
    int t0 = 0;
    int done_count = 0;
    int done_at = 0;
    bit mon_en = 1'b0;
    bit rand_ready = 1'b0;
    bit prev_hold = 1'b0;
    bit prev_done = 1'b0;
    logic [7:0] prev_data = 8'h00;

    logic [7:0] exp_q[$];
    int         exp_addr_q[$];

    assign rd_data   = regs[addr];
    assign s_rd_data = regs_s[s_addr];

    regfile_dump_reader #(.DATA_WIDTH(DW), .NREGS(NR), .ADDR_WIDTH(AW)) u_dut (
        .clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
        .o_rd_addr(addr), .i_rd_data(rd_data), .o_tx_data(data), .o_tx_valid(valid),
        .i_tx_ready(ready)
    );

    regfile_dump_reader #(.DATA_WIDTH(16), .NREGS(4), .ADDR_WIDTH(2)) u_small (
        .clk(clk), .i_rst_n(rst_n), .i_start(s_start), .o_busy(s_busy), .o_done(s_done),
        .o_rd_addr(s_addr), .i_rd_data(s_rd_data), .o_tx_data(s_data), .o_tx_valid(s_valid),
        .i_tx_ready(1'b1)
    );

    // ---------------- clock / cycle counter / ready driver ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt++;

    always @(posedge clk) begin
        #1;
        ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic fill(input int pat);
        for (int r = 0; r < NR; r++) begin
            case (pat)
                0:       regs[r] = (r == 0) ? 32'h0 : 32'h11223300 + 32'(r);
                1:       regs[r] = (r == 0) ? 32'h0 : 32'hFFFF_FFFF;
                2:       regs[r] = (r == 1) ? 32'h1 : 32'h0;
                default: regs[r] = (r == 0) ? 32'h0 : 32'($urandom);
            endcase
        end
    endtask

    task automatic build_expected();
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < BPW; k++) begin
                b = 8'((regs[r] >> (8 * k)) & 32'hFF);
                exp_q.push_back(b);
                exp_addr_q.push_back(r);
                x = x ^ b;
            end
        end
        if (CK == 1) begin
            exp_q.push_back(x);
            exp_addr_q.push_back(NR - 1);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_hold) begin
                check("hold_valid", 32'(valid), 32'd1);
                check("hold_data", 32'(data), 32'(prev_data));
            end
            prev_hold = valid && !ready;
            prev_data = data;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_byte: got %0h expected no byte", data);
                end else begin
                    check("byte", 32'(data), 32'(exp_q.pop_front()));
                    check("byte_addr", 32'(addr), 32'(exp_addr_q.pop_front()));
                end
            end
            if (done) begin
                check("done_pulse", 32'(prev_done), 32'd0);
                done_count++;
                done_at = cycle_cnt - t0 + 1;
            end
            prev_done = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_dump(input bit chk_lat, input bit pulses);
        int base;
        base = done_count;
        build_expected();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cycle_cnt;
        check("busy_first_cycle", 32'(busy), 32'd1);
        for (int i = 0; i < 4000 && done_count == base; i++) begin
            @(negedge clk);
            #1 start = (pulses && busy && $urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check("dump_done_count", 32'(done_count - base), 32'd1);
        if (chk_lat) check("done_cycle", 32'(done_at), 32'(EXP_DONE));
        @(posedge clk);
        #1;
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_single", 32'(done), 32'd0);
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        repeat (10) @(negedge clk);
        check("no_restart", 32'(busy), 32'd0);
    endtask

    task automatic run_held_start();
        int base;
        base = done_count;
        build_expected();
        build_expected();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 t0 = cycle_cnt;
        repeat (300) @(negedge clk);
        #1 start = 1'b0;
        check("held_one_dump_in_300", 32'(done_count - base), 32'd1);
        for (int i = 0; i < 1000 && done_count < base + 2; i++) @(negedge clk);
        repeat (250) @(negedge clk);
        #1;
        check("held_total_dumps", 32'(done_count - base), 32'd2);
        check("held_busy_end", 32'(busy), 32'd0);
        check("held_stream_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_reset_mid_dump();
        bit found;
        bit stayed;
        found = 1'b0;
        fill(0);
        build_expected();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (valid && addr == AW'(5) && data == 8'h22) found = 1'b1;
        end
        check("reached_r5_byte2", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        exp_q.delete();
        exp_addr_q.delete();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        stayed = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || valid || done) stayed = 1'b0;
        end
        check("idle_after_abort", 32'(stayed), 32'd1);
    endtask

    task automatic run_small();
        logic [7:0] sq[$];
        int         sa[$];
        logic [7:0] x;
        logic [7:0] b;
        int         lat;
        bit         got;
        x = 8'h00;
        got = 1'b0;
        lat = 0;
        for (int r = 0; r < 4; r++) begin
            regs_s[r] = (r == 0) ? 16'h0 : 16'($urandom);
            for (int k = 0; k < 2; k++) begin
                b = 8'((regs_s[r] >> (8 * k)) & 16'hFF);
                sq.push_back(b);
                sa.push_back(r);
                x = x ^ b;
            end
        end
        if (CK == 1) begin
            sq.push_back(x);
            sa.push_back(3);
        end
        @(negedge clk) s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        t0 = cycle_cnt;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (s_valid) begin
                if (sq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL small_extra_byte: got %0h expected no byte", s_data);
                end else begin
                    check("small_byte", 32'(s_data), 32'(sq.pop_front()));
                    check("small_addr", 32'(s_addr), 32'(sa.pop_front()));
                end
            end
            if (s_done) begin
                got = 1'b1;
                lat = cycle_cnt - t0 + 1;
            end
        end
        check("small_done_seen", 32'(got), 32'd1);
        check("small_done_cycle", 32'(lat), 32'(SMALL_DONE));
        check("small_drained", 32'(sq.size()), 32'd0);
        @(negedge clk);
        check("small_idle", 32'(s_busy), 32'd0);
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        int pat;
        bit rnd_rdy;
        bit chk_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{pat: 0, rnd_rdy: 1'b0, chk_lat: 1'b1};
        vecs[1] = '{pat: 0, rnd_rdy: 1'b1, chk_lat: 1'b0};
        vecs[2] = '{pat: 1, rnd_rdy: 1'b0, chk_lat: 1'b1};
        vecs[3] = '{pat: 2, rnd_rdy: 1'b0, chk_lat: 1'b1};
        vecs[4] = '{pat: 3, rnd_rdy: 1'b1, chk_lat: 1'b0};
        vecs[5] = '{pat: 3, rnd_rdy: 1'b0, chk_lat: 1'b1};

        rst_n   = 1'b0;
        start   = 1'b1;
        s_start = 1'b1;
        ready   = 1'b1;
        fill(0);
        for (int r = 0; r < 4; r++) regs_s[r] = 16'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data", 32'(data), 32'd0);
        check("reset_addr", 32'(addr), 32'd0);
        check("reset_small_valid", 32'(s_valid), 32'd0);
        start   = 1'b0;
        s_start = 1'b0;
        rst_n   = 1'b1;
        repeat (5) @(negedge clk);
        check("start_during_reset_ignored", 32'(busy), 32'd0);
        check("small_start_during_reset_ignored", 32'(s_busy), 32'd0);

        mon_en = 1'b1;
        for (int v = 0; v < 6; v++) begin
            fill(vecs[v].pat);
            rand_ready = vecs[v].rnd_rdy;
            run_dump(vecs[v].chk_lat, vecs[v].rnd_rdy);
        end
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);

        fill(3);
        run_held_start();
        run_reset_mid_dump();
        run_small();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
